// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, default geometry and drain length for the tile sequencer
package sa_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SWAP, STREAM, DRAIN, DONE} state_e;
    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 8;
    localparam int CNT_W_DEF = 8;
    localparam int DRAIN_LEN = ROWS_DEF + COLS_DEF - 1;
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction
endpackage

// File: rtl/sa_valid_pipe.sv
// sa_valid_pipe: enabled shift register tracking fired vectors; one tap per bottom-row column
module sa_valid_pipe
    import sa_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            en,
    input  logic            din,
    output logic [COLS-1:0] taps
);
    localparam int D = ROWS + COLS - 1;
    logic [D-1:0] sr_q, sr_d;
    // shift only on enabled cycles so the pipe freezes together with the array
    always_comb sr_d = en ? {sr_q[D-2:0], din} : sr_q;
    // shift register state
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) sr_q <= '0;
        else sr_q <= sr_d;
    end
    assign taps = sr_q[D-1:ROWS-1];
endmodule

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: load -> swap -> stream -> drain sequencer for one weight-stationary PE grid.
// Optional macro SA_WEIGHT_PREFETCH_EN: accept the next command mid-tile and load its weights
// into the shadow bank while the current tile streams/drains, then go straight to SWAP.
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_len,
    output logic                    w_rd_en,
    output logic [$clog2(ROWS)-1:0] w_row_idx,
    input  logic                    act_valid,
    output logic                    act_rd_en,
    output logic                    EN,
    output logic                    SELECTOR,
    output logic                    W_EN,
    output logic [COLS-1:0]         col_valid,
    output logic                    busy,
    output logic                    done
);
    localparam int RW = $clog2(ROWS);
    localparam int DL = drain_len(ROWS, COLS);
    localparam int DW = $clog2(ROWS + COLS);
    state_e state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d, fire_q, fire_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] drn_q, drn_d;
    logic sel_q, sel_d, drn_last;
    logic [COLS-1:0] taps;
`ifdef SA_WEIGHT_PREFETCH_EN
    localparam int PW = $clog2(ROWS + 1);
    logic pend_q, pend_d, pfd_q, pfd_d, acc;
    logic [CNT_W-1:0] plen_q, plen_d;
    logic [PW-1:0] pleft_q, pleft_d;
`endif
    assign drn_last = drn_q == DW'(DL - 1);
    assign SELECTOR = sel_q;
    // next state, counters and array control; outputs default low each cycle
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        row_d = row_q;
        fire_d = fire_q;
        drn_d = drn_q;
        sel_d = sel_q;
        cmd_ready = 1'b0;
        w_rd_en = 1'b0;
        w_row_idx = '0;
        act_rd_en = 1'b0;
        EN = 1'b0;
        W_EN = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                cmd_ready = RESET;
                if (cmd_valid) begin
                    len_d = cmd_len;
                    row_d = RW'(ROWS - 1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                EN = 1'b1;
                W_EN = 1'b1;
                w_rd_en = 1'b1;
                w_row_idx = row_q;
                row_d = row_q - 1'b1;
                if (row_q == '0) begin
                    state_d = SWAP;
                    sel_d = ~sel_q;
                end
            end
            SWAP: begin
                EN = 1'b1;
                fire_d = '0;
                drn_d = '0;
                state_d = len_q == '0 ? DONE : STREAM;
            end
            STREAM: begin
                act_rd_en = act_valid;
                EN = act_valid;
                if (act_valid) begin
                    fire_d = fire_q + 1'b1;
                    if (fire_d == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                EN = 1'b1;
                if (!drn_last) drn_d = drn_q + 1'b1;
                if (drn_last) state_d = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SA_WEIGHT_PREFETCH_EN
        pend_d = pend_q;
        plen_d = plen_q;
        pleft_d = pleft_q;
        pfd_d = 1'b0;
        acc = 1'b0;
        if (state_q == STREAM || state_q == DRAIN) begin
            cmd_ready = !pend_q;
            acc = cmd_valid && !pend_q;
            if (acc) begin
                pend_d = 1'b1;
                plen_d = cmd_len;
                pleft_d = PW'(ROWS);
            end
            if (pend_q && pleft_q != '0 && EN) begin
                W_EN = 1'b1;
                w_rd_en = 1'b1;
                w_row_idx = RW'(pleft_q - 1'b1);
                pleft_d = pleft_q - 1'b1;
            end
        end
        if (state_q == SWAP && pfd_q) done = 1'b1;
        if (state_q == DRAIN && drn_last && (pend_q || acc)) begin
            state_d = DRAIN;
            if (pend_q && pleft_q <= PW'(1)) begin
                state_d = SWAP;
                sel_d = ~sel_q;
                len_d = plen_q;
                pend_d = 1'b0;
                pfd_d = 1'b1;
            end
        end
`endif
    end
    // sequencer state registers; SELECTOR survives IDLE and only clears on reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            len_q <= '0;
            row_q <= '0;
            fire_q <= '0;
            drn_q <= '0;
            sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            row_q <= row_d;
            fire_q <= fire_d;
            drn_q <= drn_d;
            sel_q <= sel_d;
        end
    end
`ifdef SA_WEIGHT_PREFETCH_EN
    // pending next-tile command and its shadow-bank load progress
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_q <= 1'b0;
            pfd_q <= 1'b0;
            plen_q <= '0;
            pleft_q <= '0;
        end else begin
            pend_q <= pend_d;
            pfd_q <= pfd_d;
            plen_q <= plen_d;
            pleft_q <= pleft_d;
        end
    end
`endif
    sa_valid_pipe #(.ROWS(ROWS), .COLS(COLS)) u_pipe (
        .CLK  (CLK),
        .RESET(RESET),
        .en   (EN),
        .din  (act_rd_en),
        .taps (taps)
    );
    assign col_valid = EN ? taps : '0;
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb_sa_tile_sequencer: directed tiles checked each cycle against a timeline model of the sequencer
module tb_sa_tile_sequencer;
    localparam int R = 4;
    localparam int C = 4;
    localparam int W = 8;
    localparam int N = 300;
    logic CLK = 1'b0;
    logic RESET, cmd_valid, act_valid;
    logic [W-1:0] cmd_len;
    logic cmd_ready, w_rd_en, act_rd_en, EN, SELECTOR, W_EN, busy, done;
    logic [1:0] w_row_idx;
    logic [C-1:0] col_valid;
    int checks = 0;
    int failures = 0;
    logic e_en[N], e_wen[N], e_wrd[N], e_ard[N], e_busy[N], e_done[N], e_rdy[N], e_sel[N], av[N];
    int e_idx[N];
    int ecyc[N];
    logic [C-1:0] e_cv[N];
    int t_done;
    logic sel_m;

    sa_tile_sequencer #(.ROWS(R), .COLS(C), .CNT_W(W)) dut (
        .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .w_rd_en(w_rd_en), .w_row_idx(w_row_idx), .act_valid(act_valid), .act_rd_en(act_rd_en),
        .EN(EN), .SELECTOR(SELECTOR), .W_EN(W_EN), .col_valid(col_valid), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, got, exp);
        end
    endtask

    // timeline of one tile from its acceptance cycle: load, swap, stream with stalls, drain, done
    task automatic build(input int len, input logic [N-1:0] stall);
        int t, fires, ne;
        for (int i = 0; i < N; i++) begin
            e_en[i] = 0; e_wen[i] = 0; e_wrd[i] = 0; e_ard[i] = 0; e_busy[i] = 0;
            e_done[i] = 0; e_rdy[i] = 0; e_sel[i] = sel_m; e_idx[i] = 0; e_cv[i] = '0;
            av[i] = !stall[i]; ecyc[i] = 0;
        end
        e_rdy[0] = 1;
        for (int i = 1; i <= R; i++) begin
            e_en[i] = 1; e_wen[i] = 1; e_wrd[i] = 1; e_idx[i] = R - i; e_busy[i] = 1;
        end
        sel_m = !sel_m;
        t = R + 1;
        for (int i = t; i < N; i++) e_sel[i] = sel_m;
        e_en[t] = 1; e_busy[t] = 1;
        t++;
        fires = 0;
        while (fires < len) begin
            e_busy[t] = 1;
            if (av[t]) begin e_en[t] = 1; e_ard[t] = 1; fires++; end
            t++;
        end
        if (len > 0)
            for (int k = 0; k < R + C - 1; k++) begin e_en[t] = 1; e_busy[t] = 1; t++; end
        e_done[t] = 1;
        t_done = t;
        ne = 0;
        for (int i = 0; i <= t_done; i++) if (e_en[i]) begin ecyc[ne] = i; ne++; end
        for (int k = 0; k < ne; k++)
            if (e_ard[ecyc[k]])
                for (int c = 0; c < C; c++)
                    if (k + R + c < ne) e_cv[ecyc[k + R + c]][c] = 1'b1;
    endtask

    task automatic zeros(input string tag, input int t);
        chk({tag, "_ready"}, t, 32'(cmd_ready), 0);
        chk({tag, "_wrd"}, t, 32'(w_rd_en), 0);
        chk({tag, "_widx"}, t, 32'(w_row_idx), 0);
        chk({tag, "_ard"}, t, 32'(act_rd_en), 0);
        chk({tag, "_en"}, t, 32'(EN), 0);
        chk({tag, "_sel"}, t, 32'(SELECTOR), 0);
        chk({tag, "_wen"}, t, 32'(W_EN), 0);
        chk({tag, "_cv"}, t, 32'(col_valid), 0);
        chk({tag, "_busy"}, t, 32'(busy), 0);
        chk({tag, "_done"}, t, 32'(done), 0);
    endtask

    // drive one tile from cycle 0 (entered at posedge+1) and compare every cycle at the negedge
    task automatic run(input int len, input logic [N-1:0] stall, input bit hold, input int rst_at);
        build(len, stall);
        for (int t = 0; t <= t_done; t++) begin
            cmd_valid = (t == 0) || hold;
            cmd_len = W'(len);
            act_valid = av[t];
            if (t == rst_at) begin
                #2 RESET = 1'b0;
                #1 zeros("async_rst", t);
                sel_m = 1'b0;
                break;
            end
            @(negedge CLK);
            chk("cmd_ready", t, 32'(cmd_ready), 32'(e_rdy[t]));
            chk("w_rd_en", t, 32'(w_rd_en), 32'(e_wrd[t]));
            chk("w_row_idx", t, 32'(w_row_idx), 32'(e_idx[t]));
            chk("act_rd_en", t, 32'(act_rd_en), 32'(e_ard[t]));
            chk("EN", t, 32'(EN), 32'(e_en[t]));
            chk("SELECTOR", t, 32'(SELECTOR), 32'(e_sel[t]));
            chk("W_EN", t, 32'(W_EN), 32'(e_wen[t]));
            chk("col_valid", t, 32'(col_valid), 32'(e_cv[t]));
            chk("busy", t, 32'(busy), 32'(e_busy[t]));
            chk("done", t, 32'(done), 32'(e_done[t]));
            @(posedge CLK);
            #1;
        end
        cmd_valid = 1'b0;
        act_valid = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; cmd_valid = 1'b0; act_valid = 1'b0; cmd_len = '0; sel_m = 1'b0;
        #2 zeros("por", 0);
        #20 RESET = 1'b1;
        @(posedge CLK);
        #1;
        run(3, '0, 0, -1);
        chk("pin_done_cyc", 0, 32'(t_done), 16);
        chk("pin_cv10", 10, 32'(e_cv[10]), 32'h1);
        chk("pin_cv13", 13, 32'(e_cv[13]), 32'he);
        chk("pin_cv15", 15, 32'(e_cv[15]), 32'h8);
        chk("pin_ard", 6, 32'({e_ard[5], e_ard[6], e_ard[8], e_ard[9]}), 32'h6);
        chk("pin_sel", 5, 32'({e_sel[4], e_sel[5]}), 32'h1);
        chk("pin_idx1", 1, 32'(e_idx[1]), 3);
        run(3, N'(1) << 7, 0, -1);
        chk("pin_stall_done", 0, 32'(t_done), 17);
        chk("pin_stall_en7", 7, 32'(e_en[7]), 0);
        chk("pin_stall_cv", 11, 32'({e_cv[10], e_cv[11]}), 32'h1);
        run(2, '0, 1, -1);
        run(2, '0, 1, -1);
        chk("pin_b2b_sel", 5, 32'(e_sel[5]), 0);
        run(0, '0, 0, -1);
        chk("pin_len0_done", 0, 32'(t_done), 6);
        run(4, (N'(1) << 6) | (N'(1) << 8) | (N'(1) << 9), 0, -1);
        run(255, N'(1) << 40, 0, -1);
        chk("pin_max_done", 0, 32'(t_done), 269);
        run(6, '0, 0, 9);
        #20 zeros("rst_hold", 0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_ready", i, 32'(cmd_ready), 1);
            chk("post_rst_done", i, 32'(done), 0);
            chk("post_rst_busy", i, 32'(busy), 0);
            chk("post_rst_sel", i, 32'(SELECTOR), 0);
        end
        @(posedge CLK);
        #1;
        run(1, '0, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
